// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding and timing constants for the RAM port controller.
package ram_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, VSETUP, VACTIVE, VHOLD} state_e;
  localparam int CNT_W = 4;
  // The data bus is always released in IDLE, so a write is never followed by a read without an undriven cycle.
  localparam int TURNAROUND_CYCLES = 1;
endpackage

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: valid/ready to async RAM strobe sequencer; RAM_CTRL_WRVERIFY_EN adds a read-back after each write.
module ram_port_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);
`ifdef RAM_CTRL_WRVERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d, rdy_q, cs_q, wen_q, oen_q, drive_q, rv_q, accept, last;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  assign accept = req_valid & rdy_q;
  assign last = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    we_d = accept ? req_we : we_q;
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    case (state_q)
      IDLE: state_d = accept ? SETUP : IDLE;
      SETUP, VSETUP: begin
        state_d = state_q == SETUP ? ACTIVE : VACTIVE;
        cnt_d = CNT_INIT;
      end
      ACTIVE, VACTIVE: begin
        if (last) begin
          state_d = state_q == ACTIVE ? HOLD : VHOLD;
          // A verified write keeps the previous response data until its read-back lands.
          rdata_d = (state_q == ACTIVE && we_q) ? (VERIFY ? rdata_q : '0) : ram_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: state_d = (we_q && VERIFY) ? VSETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q <= 1'b0;
      cs_q <= 1'b0;
      wen_q <= 1'b0;
      oen_q <= 1'b0;
      drive_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q <= state_d == IDLE;
      cs_q <= state_d != IDLE;
      wen_q <= state_d == ACTIVE && we_d;
      oen_q <= (state_d == ACTIVE && !we_d) || state_d == VACTIVE;
      drive_q <= we_d && (state_d inside {SETUP, ACTIVE, HOLD});
      rv_q <= state_d == VHOLD || (state_d == HOLD && !(we_d && VERIFY));
    end
  end
`ifdef RAM_CTRL_WRVERIFY_EN
  logic err_q;
  always_ff @(posedge clk)
    err_q <= reset ? 1'b0 :
             (state_q == VACTIVE && last) ? ram_data != wdata_q :
             (state_q == ACTIVE && last && !we_q) ? 1'b0 : err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif
  assign req_ready = rdy_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign ram_address = addr_q;
  assign ram_cs = cs_q;
  assign ram_we = wen_q;
  assign ram_oe = oen_q;
  assign ram_data = drive_q ? wdata_q : 'z;
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed checks of two controllers (WAIT_CYCLES 1 and 3), each on a behavioural RAM.
module tb_ram_port_ctrl;
`ifdef RAM_CTRL_WRVERIFY_EN
  localparam bit WV = 1'b1;
`else
  localparam bit WV = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic v1 = 1'b0, v3 = 1'b0, req_we = 1'b0, pk = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0, pk_a = '0, pk_d = '0;
  wire rdy1, rv1, err1, cs1, we1, oe1, rdy3, rv3, err3, cs3, we3, oe3;
  wire [7:0] rd1, ad1, rd3, ad3;
  wire [7:0] bus1, bus3;
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pullup (bus1);
  pullup (bus3);
  assign bus1 = (cs1 && oe1) ? mem1[ad1] : 'z;
  assign bus3 = (cs3 && oe3) ? mem3[ad3] : 'z;
  always @(posedge clk) begin
    if (cs1 && we1) mem1[ad1] <= bus1;
    if (pk) mem1[pk_a] <= pk_d;
    if (cs3 && we3) mem3[ad3] <= bus3;
  end
  ram_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_err(err1), .ram_address(ad1), .ram_data(bus1), .ram_cs(cs1), .ram_we(we1), .ram_oe(oe1));
  ram_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3),
    .rsp_err(err3), .ram_address(ad3), .ram_data(bus3), .ram_cs(cs3), .ram_we(we3), .ram_oe(oe3));
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One access on port p (0: WAIT_CYCLES=1, 1: WAIT_CYCLES=3), checked cycle by cycle until req_ready returns.
  task automatic txn(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] rd, input bit e, input bit hold, input bit corrupt);
    int wc, lat;
    bit act, vact, e_oe, drv;
    wc = p ? 3 : 1;
    lat = (w && WV) ? 2 * wc + 4 : wc + 2;
    req_we = w;
    req_addr = a;
    req_wdata = d;
    if (p) v3 = 1'b1; else v1 = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      tick();
      if (c == 1 && !hold) begin
        v1 = 1'b0;
        v3 = 1'b0;
      end
      pk = corrupt && c == wc + 2;
      pk_a = a;
      pk_d = 8'h00;
      act = c >= 2 && c <= wc + 1;
      vact = w && WV && c >= wc + 4 && c <= 2 * wc + 3;
      e_oe = (!w && act) || vact;
      drv = w && c <= wc + 2;
      chk("cs", 8'(p ? cs3 : cs1), 8'(c <= lat));
      chk("we", 8'(p ? we3 : we1), 8'(w && act));
      chk("oe", 8'(p ? oe3 : oe1), 8'(e_oe));
      chk("we_oe_excl", 8'(p ? (we3 & oe3) : (we1 & oe1)), 8'h00);
      chk("rsp_valid", 8'(p ? rv3 : rv1), 8'(c == lat));
      chk("req_ready", 8'(p ? rdy3 : rdy1), 8'(c == lat + 1));
      chk("bus", p ? bus3 : bus1, drv ? d : (e_oe ? rd : 8'hFF));
      chk("addr", p ? ad3 : ad1, a);
      if (c >= lat) begin
        chk("rsp_rdata", p ? rd3 : rd1, rd);
        chk("rsp_err", 8'(p ? err3 : err1), 8'(e));
      end
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", 8'(rdy1), 8'h00);
    chk("rst_ready3", 8'(rdy3), 8'h00);
    chk("rst_cs_we_oe", {5'b0, cs1, we1, oe1}, 8'h00);
    chk("rst_rsp", {6'b0, rv1, err1}, 8'h00);
    chk("rst_rdata", rd1, 8'h00);
    chk("rst_addr", ad1, 8'h00);
    chk("rst_bus", bus1, 8'hFF);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 8'(rdy1), 8'h01);
    chk("post_rst_ready3", 8'(rdy3), 8'h01);
    txn(1'b0, 1'b1, 8'h10, 8'hA5, WV ? 8'hA5 : 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mem_10", mem1[8'h10], 8'hA5);
    txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 1'b1, 8'h20, 8'h3C, WV ? 8'h3C : 8'h00, 1'b0, 1'b1, 1'b0);
    txn(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("mem_20", mem3[8'h20], 8'h3C);
    req_we = 1'b1;
    req_addr = 8'h30;
    req_wdata = 8'h5A;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    chk("abort_active_we", 8'(we1), 8'h01);
    reset = 1'b1;
    tick();
    chk("abort_cs_we_oe", {5'b0, cs1, we1, oe1}, 8'h00);
    chk("abort_rsp_valid", 8'(rv1), 8'h00);
    chk("abort_bus", bus1, 8'hFF);
    chk("abort_ready", 8'(rdy1), 8'h00);
    reset = 1'b0;
    pk = 1'b1;
    pk_a = 8'h40;
    pk_d = 8'h77;
    tick();
    pk = 1'b0;
    chk("abort_ready_back", 8'(rdy1), 8'h01);
    chk("abort_no_rsp", 8'(rv1), 8'h00);
    txn(1'b0, 1'b0, 8'h40, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0);
`ifdef RAM_CTRL_WRVERIFY_EN
    txn(1'b0, 1'b1, 8'h50, 8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 8'h50, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
